memory_access: RTL
==================

# memory_access

Memory-access stage of the RV32I pipeline, directly downstream of the execute stage. It takes execute's registered outputs (effective address, store data, funct3, destination register, writeback data) and turns loads and stores into transactions on a req/ack data-memory bus. It aligns and sign/zero-extends load data and back-pressures the upstream stage while a transaction is outstanding. Non-memory instructions pass through to writeback with one register stage.

## Interface
Parameters:
- AWIDTH, 5, register address width
- DWIDTH, 32, data/address width; only 32 is supported
- FUNCT_WIDTH, 3, funct3 width
- PC_WIDTH, 32, PC width

Ports (opcode width and encodings come from header.vh: `OPCODE_WIDTH, `LOAD_WORD, `STORE_WORD):
- me_clk  in  1  clock; all state changes on the rising edge
- me_rst  in  1  reset, synchronous, active-high
- me_i_ce  in  1  input instruction valid
- me_i_flush  in  1  squash the instruction being accepted this cycle
- me_i_opcode  in  `OPCODE_WIDTH  instruction opcode
- me_i_funct3  in  FUNCT_WIDTH  access size/sign
- me_i_alu_value  in  DWIDTH  effective address (loads/stores)
- me_i_data_rs2  in  DWIDTH  store data
- me_i_data_rd  in  DWIDTH  result for non-memory ops
- me_i_addr_rd  in  AWIDTH  destination register
- me_i_we_reg  in  1  register write enable for non-memory ops
- me_i_pc  in  PC_WIDTH  instruction PC
- me_o_stall  out  1  upstream must hold its outputs
- me_o_req, me_o_we  out  1  bus request; write (1) or read (0)
- me_o_addr  out  DWIDTH  word-aligned bus address
- me_o_wdata  out  DWIDTH  lane-replicated store data
- me_o_wstrb  out  4  byte strobes
- me_i_ack  in  1  bus completion
- me_i_rdata  in  DWIDTH  read data, valid with ack
- me_o_ce, me_o_we_reg  out  1  writeback valid / register write
- me_o_addr_rd  out  AWIDTH  destination register
- me_o_data_rd  out  DWIDTH  writeback data
- me_o_pc  out  PC_WIDTH  PC of retiring instruction

## Operation
- FSM with two states: IDLE and BUS. Reset sets IDLE.
- In IDLE, the stage accepts when me_i_ce=1 and me_i_flush=0. Otherwise the input is dropped.
- Accepted non-memory op: next edge registers me_o_ce=1, me_o_we_reg=me_i_we_reg, data_rd, addr_rd, pc. State stays IDLE.
- Accepted load/store:
  - next edge latches address, funct3, rd, pc, store data.
  - drives me_o_req=1, me_o_addr={addr[31:2],2'b00}, me_o_we=store, me_o_wstrb, me_o_wdata.
  - goes to BUS.
- Store lanes:
  - SB (000): strb=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH (001): strb=0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}.
  - SW (010): strb=1111, wdata=rs2.
- In BUS, req/addr/we/wstrb/wdata are held stable until an edge samples me_i_ack=1. On that edge:
  - req drops to 0 and state returns to IDLE.
  - me_o_ce=1 for one cycle.
  - Load: me_o_we_reg=1; data_rd is the lane of rdata selected by addr. LB/LH sign-extend, LBU (100)/LHU (101) zero-extend, LW whole word.
  - Store: me_o_we_reg=0.
- me_o_stall = (state==BUS), combinational from state. Upstream holds its instruction, and it is accepted in the cycle after ack.
- me_o_ce and me_o_we_reg are 0 in every cycle not listed above.
- me_i_flush is ignored in BUS; the outstanding access is older than the flushing instruction and completes.
- me_i_ack in IDLE is ignored.
- Reset in BUS: at the next edge req=0 and state=IDLE. A later ack is ignored.
- Reset values: me_o_req, me_o_we, me_o_ce, me_o_we_reg = 0. me_o_wstrb = 0. me_o_addr, me_o_wdata, me_o_data_rd, me_o_pc = 0. me_o_addr_rd = 0. me_o_stall = 0.

## Timing
- Non-memory op: accepted at edge N, visible on writeback outputs in cycle N+1 (1-cycle latency).
- Memory op accepted at edge N: req high from cycle N+1.
- Ack sampled at edge N+k (k≥1): result on outputs in cycle N+k+1, and stall deasserts in that same cycle.
- With zero-wait memory (ack=1 in the first req cycle), load latency is 2 cycles.
- Back-to-back memory ops: one idle cycle between req pulses (the acceptance cycle).

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, is misaligned.
  - A misaligned access issues no request and stays IDLE.
  - Next edge sets me_o_ce=1, me_o_we_reg=0, and the extra output port me_o_misaligned=1 for one cycle (reset 0).
- Undefined: no port. Halfwords use addr[1] only and words ignore addr[1:0]. The access proceeds normally.

## Test plan
- ADD result 0x00000007 to rd=5, me_i_ce=1 → next cycle me_o_ce=1, we_reg=1, addr_rd=5, data_rd=0x7, no req.
- SB rs2=0x000000A5 at addr 0x1002, ack after 3 req cycles → req held 3 cycles with addr 0x1000, strb 0100, wdata 0xA5A5A5A5, stall high throughout; then me_o_ce=1, we_reg=0.
- LB at 0x2003 with rdata 0x80FFFFFF, zero-wait ack → data_rd=0xFFFFFF80 two cycles after acceptance. LBU same → 0x00000080. LHU at 0x2002 with rdata 0x8001FFFF → 0x00008001.
- Flush: ce=1, flush=1 with LW → no req, me_o_ce stays 0. Flush asserted during BUS → access still completes with correct data.
- Reset asserted in 2nd wait cycle of LW, then ack=1 → req=0 and all outputs 0 after the reset edge; the ack produces no me_o_ce.
- With MEM_MISALIGN_CHECK_EN: SW at 0x3001 → no req, me_o_misaligned=1 and me_o_ce=1 for one cycle. Without the macro: req with addr 0x3000, strb 1111.

Source files
------------

// File: rtl/memory_access.sv
// RV32I memory-access stage: turns loads/stores into req/ack bus transactions, aligns load data.
// Optional build macro MEM_MISALIGN_CHECK_EN adds misalignment trapping and the me_o_misaligned port.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD_WORD
`define LOAD_WORD 7'b0000011
`endif
`ifndef STORE_WORD
`define STORE_WORD 7'b0100011
`endif

module memory_access #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 3,
  parameter int PC_WIDTH    = 32
) (
  input  logic                     me_clk,
  input  logic                     me_rst,
  input  logic                     me_i_ce,
  input  logic                     me_i_flush,
  input  logic [`OPCODE_WIDTH-1:0] me_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]   me_i_funct3,
  input  logic [DWIDTH-1:0]        me_i_alu_value,
  input  logic [DWIDTH-1:0]        me_i_data_rs2,
  input  logic [DWIDTH-1:0]        me_i_data_rd,
  input  logic [AWIDTH-1:0]        me_i_addr_rd,
  input  logic                     me_i_we_reg,
  input  logic [PC_WIDTH-1:0]      me_i_pc,
  output logic                     me_o_stall,
  output logic                     me_o_req,
  output logic                     me_o_we,
  output logic [DWIDTH-1:0]        me_o_addr,
  output logic [DWIDTH-1:0]        me_o_wdata,
  output logic [3:0]               me_o_wstrb,
  input  logic                     me_i_ack,
  input  logic [DWIDTH-1:0]        me_i_rdata,
  output logic                     me_o_ce,
  output logic                     me_o_we_reg,
  output logic [AWIDTH-1:0]        me_o_addr_rd,
  output logic [DWIDTH-1:0]        me_o_data_rd,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic                     me_o_misaligned,
`endif
  output logic [PC_WIDTH-1:0]      me_o_pc
);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e              state_q;
  logic                req_q;
  logic                we_q;
  logic [DWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [3:0]          wstrb_q;
  logic                ce_q;
  logic                we_reg_q;
  logic [AWIDTH-1:0]   addr_rd_q;
  logic [DWIDTH-1:0]   data_rd_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                misaligned_q;

  // Details of the outstanding access, retired into the writeback registers on ack.
  logic [2:0]          f3_pend_q;
  logic [1:0]          off_pend_q;
  logic [AWIDTH-1:0]   rd_pend_q;
  logic [PC_WIDTH-1:0] pc_pend_q;

  logic                accept_s;
  logic                is_load_s;
  logic                is_store_s;
  logic                misaligned_s;
  logic [1:0]          off_s;

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3)
      F3_B:    strb = 4'b0001 << off;
      F3_H:    strb = 4'b0011 << {off[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] lanes;
    case (f3)
      F3_B:    lanes = {4{rs2[7:0]}};
      F3_H:    lanes = {2{rs2[15:0]}};
      default: lanes = rs2;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h000000, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0000, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction
`endif

  assign off_s      = me_i_alu_value[1:0];
  assign accept_s   = me_i_ce && !me_i_flush;
  assign is_load_s  = (me_i_opcode == `LOAD_WORD);
  assign is_store_s = (me_i_opcode == `STORE_WORD);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned_s = (is_load_s || is_store_s) && is_misaligned(me_i_funct3, off_s);
  assign me_o_misaligned = misaligned_q;
`else
  assign misaligned_s = 1'b0;
`endif

  // Stage FSM: issues bus requests and owns every registered output.
  always_ff @(posedge me_clk) begin
    if (me_rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      wstrb_q      <= 4'b0000;
      ce_q         <= 1'b0;
      we_reg_q     <= 1'b0;
      addr_rd_q    <= '0;
      data_rd_q    <= 32'h0000_0000;
      pc_q         <= '0;
      misaligned_q <= 1'b0;
      f3_pend_q    <= 3'b000;
      off_pend_q   <= 2'b00;
      rd_pend_q    <= '0;
      pc_pend_q    <= '0;
    end else begin
      ce_q         <= 1'b0;
      we_reg_q     <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!accept_s) begin
            state_q <= IDLE;
          end else if (misaligned_s) begin
            ce_q         <= 1'b1;
            misaligned_q <= 1'b1;
            addr_rd_q    <= me_i_addr_rd;
            pc_q         <= me_i_pc;
          end else if (is_load_s || is_store_s) begin
            state_q    <= BUS;
            req_q      <= 1'b1;
            we_q       <= is_store_s;
            addr_q     <= {me_i_alu_value[31:2], 2'b00};
            wstrb_q    <= is_store_s ? store_strobe(me_i_funct3, off_s) : 4'b0000;
            wdata_q    <= store_lanes(me_i_funct3, me_i_data_rs2);
            f3_pend_q  <= me_i_funct3;
            off_pend_q <= off_s;
            rd_pend_q  <= me_i_addr_rd;
            pc_pend_q  <= me_i_pc;
          end else begin
            ce_q      <= 1'b1;
            we_reg_q  <= me_i_we_reg;
            data_rd_q <= me_i_data_rd;
            addr_rd_q <= me_i_addr_rd;
            pc_q      <= me_i_pc;
          end
        end
        BUS: begin
          // Flush is deliberately ignored here: the outstanding access is older.
          if (me_i_ack) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            ce_q      <= 1'b1;
            we_reg_q  <= !we_q;
            addr_rd_q <= rd_pend_q;
            pc_q      <= pc_pend_q;
            if (!we_q) begin
              data_rd_q <= load_extend(f3_pend_q, off_pend_q, me_i_rdata);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign me_o_stall   = (state_q == BUS);
  assign me_o_req     = req_q;
  assign me_o_we      = we_q;
  assign me_o_addr    = addr_q;
  assign me_o_wdata   = wdata_q;
  assign me_o_wstrb   = wstrb_q;
  assign me_o_ce      = ce_q;
  assign me_o_we_reg  = we_reg_q;
  assign me_o_addr_rd = addr_rd_q;
  assign me_o_data_rd = data_rd_q;
  assign me_o_pc      = pc_q;

endmodule
